// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the key expander and the cipher datapath.
//   AES_NR     - number of AES-128 rounds (10)
//   AES_RED    - GF(2^8) reduction constant for xtime (x^8 = x^4+x^3+x+1)
//   round_key_t- one 128-bit round key, byte 0 in [127:120]
//   ke_state_t - key expander FSM states
//   xtime/gf_mul - GF(2^8) helpers
package aes_pkg;

  localparam int         AES_NR  = 10;
  localparam logic [7:0] AES_RED = 8'h1B;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ke_state_t;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_RED : 8'h00);
  endfunction

  // Full GF(2^8) multiply, shift-and-add over xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: 8-bit combinational AES forward S-box.
//   x - input byte
//   y - substituted byte
// Computed as multiplicative inverse (x^254, with 0 -> 0) followed by the
// affine transform, instead of a 256-entry table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  logic [7:0] pw;
  logic [7:0] inv;

  // x^254 = x^2 * x^4 * ... * x^128; squaring chain accumulates the product.
  always_comb begin
    pw  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
  end

  // Affine map: b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3) ^ rotl(b,4) ^ 0x63.
  assign y = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

// File: rtl/key_expander.sv
// key_expander: AES-128 key schedule, one round key per clock.
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   load_key     - key-change request level; a rising edge seen in IDLE starts expansion
//   key_in       - cipher key, [127:120] = key byte 0, sampled only on acceptance
//   rk_sel       - round-key read index 0..10 (others read zero)
//   rev          - (KEY_EXPANDER_REV_READ_EN only) read rk[10-rk_sel]
//   rk_out       - selected round key, combinational from the register file
//   chg_key_done - one-cycle pulse when rk[10] has been written
//   busy         - expansion in progress
//   key_valid    - all stored round keys belong to one complete expansion
// Optional feature macro: KEY_EXPANDER_REV_READ_EN (reverse read ordering).
module key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_key,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_sel,
`ifdef KEY_EXPANDER_REV_READ_EN
  input  logic         rev,
`endif
  output logic [127:0] rk_out,
  output logic         chg_key_done,
  output logic         busy,
  output logic         key_valid
);

  generate
    if (NR != AES_NR) begin : g_nr_check
      $error("key_expander: only NR=10 (AES-128) is supported");
    end
  endgenerate

  ke_state_t  state, state_nxt;
  logic       load_q;
  logic       armed;
  logic [3:0] cnt;
  logic [7:0] rcon;
  round_key_t rk [0:NR];

  logic       accept;
  round_key_t prev_key;
  round_key_t next_key;
  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] tmp_w;
  logic [3:0]  rd_idx;

  // armed blocks a load_key that was already high when reset released; it
  // must be seen low at least once before an edge can be accepted.
  assign accept = (state == IDLE) && load_key && !load_q && armed;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (cnt == 4'(NR)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy         = 1'b0;
    chg_key_done = 1'b0;
    case (state)
      EXPAND:  busy = 1'b1;
      DONE:    chg_key_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- key schedule datapath ----------------
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++)
      if (cnt == 4'(i + 1)) prev_key = rk[i];
  end

  assign rot_w = {prev_key[23:0], prev_key[31:24]};

  genvar j;
  generate
    for (j = 0; j < 4; j++) begin : g_sbox
      aes_sbox u_sbox (
        .x (rot_w[8*j +: 8]),
        .y (sub_w[8*j +: 8])
      );
    end
  endgenerate

  assign tmp_w = sub_w ^ {rcon, 24'h0};

  // Each word chains off the one before it in the new key.
  always_comb begin
    next_key[127:96] = prev_key[127:96] ^ tmp_w;
    next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
    next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
    next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q    <= 1'b0;
      armed     <= 1'b0;
      cnt       <= 4'd0;
      rcon      <= 8'h01;
      key_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      load_q <= load_key;
      if (!load_key) armed <= 1'b1;
      if (accept) begin
        rk[0]     <= key_in;
        cnt       <= 4'd1;
        rcon      <= 8'h01;
        key_valid <= 1'b0;
      end else if (state == EXPAND) begin
        for (int i = 1; i <= NR; i++)
          if (cnt == 4'(i)) rk[i] <= next_key;
        cnt  <= cnt + 4'd1;
        rcon <= xtime(rcon);
        if (cnt == 4'(NR)) key_valid <= 1'b1;
      end
    end
  end

  // ---------------- read port ----------------
`ifdef KEY_EXPANDER_REV_READ_EN
  assign rd_idx = rev ? (4'(NR) - rk_sel) : rk_sel;
`else
  assign rd_idx = rk_sel;
`endif

  always_comb begin
    rk_out = '0;
    if (rk_sel <= 4'(NR))
      for (int i = 0; i <= NR; i++)
        if (rd_idx == 4'(i)) rk_out = rk[i];
  end

endmodule

// File: tb/tb_key_expander.sv
module tb_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_key;
  logic [127:0] key_in;
  logic [3:0]   rk_sel;
  logic         rev;
  logic [127:0] rk_out;
  logic         chg_key_done;
  logic         busy;
  logic         key_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] ref_rk [0:10];

  key_expander #(.NR(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_key     (load_key),
    .key_in       (key_in),
    .rk_sel       (rk_sel),
`ifdef KEY_EXPANDER_REV_READ_EN
    .rev          (rev),
`endif
    .rk_out       (rk_out),
    .chg_key_done (chg_key_done),
    .busy         (busy),
    .key_valid    (key_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = b;
    end
  endtask

  // Textbook word-oriented key expansion.
  task automatic expand_ref(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [7:0]  rc [0:9];
    logic [31:0] t;
    rc[0] = 8'h01; rc[1] = 8'h02; rc[2] = 8'h04; rc[3] = 8'h08; rc[4] = 8'h10;
    rc[5] = 8'h20; rc[6] = 8'h40; rc[7] = 8'h80; rc[8] = 8'h1b; rc[9] = 8'h36;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int s = 0; s < 11; s++) begin
      rk_sel = 4'(s);
      #1;
      chk($sformatf("%s_rk%0d", tag, s), rk_out, ref_rk[s]);
    end
  endtask

  // One accepted load_key pulse; optionally scramble key_in after E0.
  task automatic do_expand(input string tag, input logic [127:0] k, input bit scramble);
    expand_ref(k);
    key_in   = k;
    load_key = 1'b1;
    step();                       // E0
    load_key = 1'b0;
    chk({tag, "_busy_e0"}, 128'(busy), 128'd1);
    chk({tag, "_kv_e0"}, 128'(key_valid), 128'd0);
    for (int i = 1; i <= 10; i++) begin
      if (scramble) key_in = {$urandom, $urandom, $urandom, $urandom};
      step();                     // E0+i
      chk($sformatf("%s_done_e%0d", tag, i), 128'(chg_key_done), 128'(i == 10));
    end
    chk({tag, "_kv_e10"}, 128'(key_valid), 128'd1);
    chk({tag, "_busy_e10"}, 128'(busy), 128'd0);
    step();                       // E0+11
    chk({tag, "_done_e11"}, 128'(chg_key_done), 128'd0);
    chk({tag, "_kv_e11"}, 128'(key_valid), 128'd1);
    read_all(tag);
  endtask

  initial begin
    int n_done, n_busy;
    logic [127:0] k;

    build_sbox();
    rst = 1'b1; load_key = 1'b0; key_in = '0; rk_sel = '0; rev = 1'b0;
    step(); step();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(chg_key_done), 128'd0);
    chk("rst_kv", 128'(key_valid), 128'd0);
    chk("rst_rk0", rk_out, 128'd0);
    rst = 1'b0;
    step();

    // FIPS-197 vector
    do_expand("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rk_sel = 4'd1;  #1; chk("fips_rk1_const", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_sel = 4'd10; #1; chk("fips_rk10_const", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // out-of-range reads
    for (int s = 11; s < 16; s++) begin
      rk_sel = 4'(s); #1;
      chk($sformatf("oor_sel%0d", s), rk_out, 128'd0);
    end
`ifdef KEY_EXPANDER_REV_READ_EN
    rev = 1'b1;
    rk_sel = 4'd0; #1; chk("rev_sel0", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int s = 0; s < 16; s++) begin
      rk_sel = 4'(s); #1;
      chk($sformatf("rev_sel%0d", s), rk_out, (s <= 10) ? ref_rk[10 - s] : 128'd0);
    end
    rev = 1'b0;
`endif

    // all-zero key
    do_expand("zero", 128'd0, 1'b0);
    rk_sel = 4'd10; #1; chk("zero_rk10_const", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // random keys, key_in disturbed after acceptance
    for (int r = 0; r < 5; r++) begin
      step();
      do_expand($sformatf("rnd%0d", r), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end

    // load_key held high for 20 cycles -> exactly one expansion
    k = {$urandom, $urandom, $urandom, $urandom};
    expand_ref(k);
    key_in = k; load_key = 1'b1;
    n_done = 0; n_busy = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n_done += int'(chg_key_done);
      n_busy += int'(busy);
    end
    load_key = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_done += int'(chg_key_done);
      n_busy += int'(busy);
    end
    chk("hold_done_pulses", 128'(n_done), 128'd1);
    chk("hold_busy_cycles", 128'(n_busy), 128'd10);
    read_all("hold");

    // reset at E0+5
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in = k; load_key = 1'b1;
    step();
    load_key = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("mid_busy_pre", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_kv", 128'(key_valid), 128'd0);
    chk("mid_done", 128'(chg_key_done), 128'd0);
    for (int s = 0; s < 16; s++) begin
      rk_sel = 4'(s); #1;
      chk($sformatf("mid_rk%0d", s), rk_out, 128'd0);
    end
    step();
    // release reset with load_key already high: must not start
    load_key = 1'b1;
    step();
    rst = 1'b0;
    n_done = 0; n_busy = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      n_done += int'(chg_key_done);
      n_busy += int'(busy);
    end
    chk("post_rst_done", 128'(n_done), 128'd0);
    chk("post_rst_busy", 128'(n_busy), 128'd0);
    chk("post_rst_kv", 128'(key_valid), 128'd0);
    load_key = 1'b0;
    step();
    do_expand("after_rst", {$urandom, $urandom, $urandom, $urandom}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
